// File: rtl/eb_pkg.sv
// Shared definitions for the elastic-buffer SKP scheduler: state encoding and default tuning.
package eb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADD_WAIT = 2'd1,
    COOL     = 2'd2,
    DEL_HOLD = 2'd3
  } sched_state_t;

  localparam int unsigned BUFFER_DEPTH_DEF = 16;
  localparam int unsigned LOW_WM_DEF       = 4;
  localparam int unsigned HIGH_WM_DEF      = 12;
  localparam int unsigned COOLDOWN_DEF     = 4;
  localparam int unsigned ADD_TIMEOUT_DEF  = 64;
  localparam int unsigned SKP_CNT_W        = 8;

endpackage

// File: rtl/grayToBin.sv
// Combinational Gray-code to binary converter.
module grayToBin #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin_c
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      bin_c[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/eb_skp_scheduler.sv
// Elastic-buffer SKP scheduler: tracks fill level in the read domain and
// requests SKP insertion/deletion to keep occupancy between watermarks.
// COOLDOWN and ADD_TIMEOUT must be at least 1.
module eb_skp_scheduler
  import eb_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = BUFFER_DEPTH_DEF,
  parameter int unsigned LOW_WM       = LOW_WM_DEF,
  parameter int unsigned HIGH_WM      = HIGH_WM_DEF,
  parameter int unsigned COOLDOWN     = COOLDOWN_DEF,
  parameter int unsigned ADD_TIMEOUT  = ADD_TIMEOUT_DEF
) (
  input  logic                          read_clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clr_err,
  input  logic [$clog2(BUFFER_DEPTH):0] gray_write_pointer,
  input  logic [$clog2(BUFFER_DEPTH):0] gray_read_pointer,
  input  logic                          skp_added,
  output logic                          add_req,
  output logic                          del_req,
  output logic [$clog2(BUFFER_DEPTH):0] occupancy,
  output logic                          add_timeout_err,
  output logic                          starve_err,
  output logic                          overflow_err,
  output logic [SKP_CNT_W-1:0]          skp_add_count
);

  localparam int unsigned PW     = $clog2(BUFFER_DEPTH) + 1;
  localparam int unsigned TMAX   = (ADD_TIMEOUT > COOLDOWN) ? ADD_TIMEOUT : COOLDOWN;
  localparam int unsigned TW     = $clog2(TMAX + 1);
  localparam logic [SKP_CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0] wsync1, wsync2;
  logic [PW-1:0] wbin_c, rbin_c;
  sched_state_t  state_q, state_nxt;
  logic [TW-1:0] tmr_q;
  logic          add_done, add_tout;
  logic          starve_set, ovf_set;

  grayToBin #(.W(PW)) u_wg2b (.gray(wsync2),            .bin_c(wbin_c));
  grayToBin #(.W(PW)) u_rg2b (.gray(gray_read_pointer), .bin_c(rbin_c));

  // Two-flop write-pointer synchronizer and registered fill level (modulo subtraction covers wrap).
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      wsync1    <= '0;
      wsync2    <= '0;
      occupancy <= '0;
    end else begin
      wsync1    <= gray_write_pointer;
      wsync2    <= wsync1;
      occupancy <= wbin_c - rbin_c;
    end
  end

  // Next-state logic; enable low overrides everything and parks the FSM in IDLE.
  always_comb begin
    state_nxt = state_q;
    add_done  = 1'b0;
    add_tout  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (occupancy < PW'(LOW_WM))       state_nxt = ADD_WAIT;
          else if (occupancy > PW'(HIGH_WM)) state_nxt = DEL_HOLD;
        end
        ADD_WAIT: begin
          if (skp_added) begin
            add_done  = 1'b1;
            state_nxt = COOL;
          end else if (tmr_q == TW'(ADD_TIMEOUT - 1)) begin
            add_tout  = 1'b1;
            state_nxt = COOL;
          end
        end
        COOL: begin
          if (tmr_q == TW'(COOLDOWN - 1)) state_nxt = IDLE;
        end
        DEL_HOLD: begin
          if (occupancy <= PW'(BUFFER_DEPTH / 2)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign starve_set = enable && (occupancy == '0);
  assign ovf_set    = occupancy > PW'(BUFFER_DEPTH);

  // State register, per-state dwell timer and registered requests.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      add_req <= 1'b0;
      del_req <= 1'b0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= (state_nxt != state_q) ? '0 : tmr_q + TW'(1);
      add_req <= (state_nxt == ADD_WAIT);
      del_req <= (state_nxt == DEL_HOLD);
    end
  end

  // Saturating add counter and sticky error flags; a set beats a same-cycle clear.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      skp_add_count   <= '0;
      add_timeout_err <= 1'b0;
      starve_err      <= 1'b0;
      overflow_err    <= 1'b0;
    end else begin
      if (add_done && (skp_add_count != CNT_MAX)) skp_add_count <= skp_add_count + SKP_CNT_W'(1);
      add_timeout_err <= add_tout   | (add_timeout_err & ~clr_err);
      starve_err      <= starve_set | (starve_err      & ~clr_err);
      overflow_err    <= ovf_set    | (overflow_err    & ~clr_err);
    end
  end

endmodule
